// File: rtl/agm_read_unpacker.sv
// Read side of the asymmetric dual-port buffer: fetches 32-bit words from port B,
// absorbs the BRAM read latency and streams each word out as four bytes, lane 0 first.
module agm_read_unpacker #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              Readclk,
  input  logic              reset,
  input  logic              Enrd,
  input  logic              avail,
  input  logic [WORD_W-1:0] doutb,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  output logic              rd_ack,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy
);

  localparam int LANES  = WORD_W / BYTE_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [LAT_W-1:0]               lat_cnt;
  logic [LANE_W-1:0]              lane_idx;
  logic [LANE_W-1:0]              lane_next;
  logic [LANES-1:0][BYTE_W-1:0]   word_q;
  logic                           accept;
  logic                           last_lane;
  logic                           start_fetch;

  assign accept      = dout_valid && dout_ready;
  assign last_lane   = (lane_idx == LANE_W'(LANES - 1));
  assign lane_next   = lane_idx + 1'b1;
  // Empty guard: a fetch is only ever started when a whole word is waiting.
  assign start_fetch = Enrd && avail;
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge Readclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    enb        = 1'b0;
    rd_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (start_fetch) state_next = FETCH;
      end
      FETCH: begin
        enb        = 1'b1;
        rd_ack     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) state_next = EMIT;
      end
      EMIT: begin
        if (accept && last_lane) state_next = start_fetch ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Readclk or negedge reset) begin
    if (!reset) begin
      addrb      <= '0;
      lat_cnt    <= '0;
      lane_idx   <= '0;
      word_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          addrb   <= addrb + 1'b1;
          lat_cnt <= LAT_W'(RD_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            // doutb is only trusted on this edge; lane 0 is presented straight away.
            word_q     <= doutb;
            lane_idx   <= '0;
            dout       <= doutb[BYTE_W-1:0];
            dout_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        EMIT: begin
          if (accept) begin
            if (last_lane) begin
              lane_idx   <= '0;
              dout_valid <= 1'b0;
            end else begin
              lane_idx <= lane_next;
              dout     <= word_q[lane_next];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_agm_read_unpacker.sv
// Directed bench for agm_read_unpacker: a registered BRAM model feeds doutb and
// monitors log every rd_ack pulse and every accepted byte for later comparison.
module tb_agm_read_unpacker;

  localparam int ADDR_W = 9;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              Enrd;
  logic              avail;
  logic [WORD_W-1:0] doutb = '0;
  logic [ADDR_W-1:0] addrb;
  logic              enb;
  logic              rd_ack;
  logic [BYTE_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;

  logic [WORD_W-1:0] mem [512];
  logic [ADDR_W-1:0] addr_q [$];
  logic [BYTE_W-1:0] byte_q [$];
  int                ack_cnt = 0;
  int                n_checks = 0;
  int                n_pass = 0;

  agm_read_unpacker dut (
    .Readclk    (clk),
    .reset      (reset),
    .Enrd       (Enrd),
    .avail      (avail),
    .doutb      (doutb),
    .addrb      (addrb),
    .enb        (enb),
    .rd_ack     (rd_ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Port-B model with one cycle of read latency.
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  always @(posedge clk) begin
    if (rd_ack) begin
      ack_cnt++;
      addr_q.push_back(addrb);
    end
    if (dout_valid && dout_ready) byte_q.push_back(dout);
  end

  function automatic logic [31:0] exp_word(input int a);
    if (a == 0) return 32'hDDCCBBAA;
    return {4{8'(a)}};
  endfunction

  function automatic logic [31:0] exp_byte(input int k);
    logic [31:0] w;
    w = exp_word(k / 4);
    return 32'(w[8*(k%4) +: 8]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!dout_valid && n < 20) begin
      step();
      n++;
    end
    if (!dout_valid) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) check(tag, 32'd1, 32'd0);
  endtask

  // Streams words until `words` fetches have been issued, then drops avail and waits for idle.
  task automatic run_stream(input string tag, input int words, input int budget);
    int a0 = ack_cnt;
    int n  = 0;
    avail = 1'b1;
    pulse_reset();
    while (n < budget) begin
      step();
      n++;
      if (ack_cnt - a0 >= words) begin
        avail = 1'b0;
        if (!busy) break;
      end
    end
    if (busy || (ack_cnt - a0 < words)) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] lanes [4];
    int a0;
    int b0;
    lanes[0] = 8'hAA; lanes[1] = 8'hBB; lanes[2] = 8'hCC; lanes[3] = 8'hDD;
    for (int a = 0; a < 512; a++) mem[a] = exp_word(a);

    // Reset held with the fetch conditions already true.
    reset = 1'b0; Enrd = 1'b1; avail = 1'b1; dout_ready = 1'b1;
    repeat (3) step();
    check("rst_addrb", 32'(addrb), 32'd0);
    check("rst_enb", 32'(enb), 32'd0);
    check("rst_rd_ack", 32'(rd_ack), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);

    // Single word: FETCH right after release, bytes from two cycles after FETCH.
    reset = 1'b1;
    step();
    check("fetch_enb", 32'(enb), 32'd1);
    check("fetch_rd_ack", 32'(rd_ack), 32'd1);
    check("fetch_addrb", 32'(addrb), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    avail = 1'b0;
    step();
    check("wait_enb", 32'(enb), 32'd0);
    check("wait_rd_ack", 32'(rd_ack), 32'd0);
    check("wait_valid", 32'(dout_valid), 32'd0);
    check("wait_addrb", 32'(addrb), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("single_valid", 32'(dout_valid), 32'd1);
      check("single_byte", 32'(dout), 32'(lanes[i]));
    end
    step();
    check("single_done_valid", 32'(dout_valid), 32'd0);
    check("single_done_busy", 32'(busy), 32'd0);
    check("single_acks", 32'(ack_cnt), 32'd1);
    check("single_addrb", 32'(addrb), 32'd1);

    // Backpressure on lane 1.
    a0 = ack_cnt; b0 = byte_q.size();
    avail = 1'b1;
    pulse_reset();
    step();
    avail = 1'b0;
    wait_valid("bp_timeout");
    check("bp_lane0", 32'(dout), 32'hAA);
    step();
    check("bp_lane1", 32'(dout), 32'hBB);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_byte", 32'(dout), 32'hBB);
      check("bp_hold_valid", 32'(dout_valid), 32'd1);
    end
    dout_ready = 1'b1;
    step();
    check("bp_lane2", 32'(dout), 32'hCC);
    step();
    check("bp_lane3", 32'(dout), 32'hDD);
    step();
    check("bp_done_valid", 32'(dout_valid), 32'd0);
    check("bp_byte_count", 32'(byte_q.size() - b0), 32'd4);
    for (int i = 0; i < 4 && b0 + i < byte_q.size(); i++)
      check("bp_stream", 32'(byte_q[b0+i]), 32'(lanes[i]));
    check("bp_acks", 32'(ack_cnt - a0), 32'd1);

    // Back-to-back stream of 8 words.
    a0 = ack_cnt; b0 = byte_q.size();
    run_stream("stream_timeout", 8, 200);
    check("stream_acks", 32'(ack_cnt - a0), 32'd8);
    check("stream_addrb", 32'(addrb), 32'd8);
    check("stream_byte_count", 32'(byte_q.size() - b0), 32'd32);
    for (int k = 0; k < 32 && b0 + k < byte_q.size(); k++)
      check("stream_byte", 32'(byte_q[b0+k]), exp_byte(k));

    // Wrap: words 0..511 then 0 again.
    a0 = ack_cnt; b0 = byte_q.size();
    run_stream("wrap_timeout", 513, 5000);
    check("wrap_acks", 32'(ack_cnt - a0), 32'd513);
    check("wrap_addr_511", 32'(addr_q[a0+511]), 32'd511);
    check("wrap_addr_0", 32'(addr_q[a0+512]), 32'd0);
    check("wrap_addrb", 32'(addrb), 32'd1);
    check("wrap_byte_count", 32'(byte_q.size() - b0), 32'd2052);
    for (int k = 0; k < 8 && b0 + 2044 + k < byte_q.size(); k++)
      check("wrap_byte", 32'(byte_q[b0+2044+k]), (k < 4) ? exp_byte(2044 + k) : exp_byte(k - 4));

    // Empty guard: avail low keeps the block idle.
    a0 = ack_cnt;
    repeat (5) step();
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_enb", 32'(enb), 32'd0);
    check("empty_acks", 32'(ack_cnt - a0), 32'd0);

    // Enrd dropped during lane 1: the word still completes.
    a0 = ack_cnt; b0 = byte_q.size();
    avail = 1'b1;
    pulse_reset();
    wait_valid("enrd_timeout");
    check("enrd_lane0", 32'(dout), 32'hAA);
    step();
    check("enrd_lane1", 32'(dout), 32'hBB);
    Enrd = 1'b0;
    wait_idle("enrd_idle_timeout", 20);
    check("enrd_byte_count", 32'(byte_q.size() - b0), 32'd4);
    repeat (3) step();
    check("enrd_acks", 32'(ack_cnt - a0), 32'd1);
    check("enrd_busy", 32'(busy), 32'd0);

    // Reset during lane 2 clears outputs without a clock edge.
    Enrd = 1'b1;
    pulse_reset();
    wait_valid("rstmid_timeout");
    step();
    step();
    check("rstmid_lane2", 32'(dout), 32'hCC);
    reset = 1'b0;
    #1;
    check("rstmid_valid", 32'(dout_valid), 32'd0);
    check("rstmid_addrb", 32'(addrb), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_enb", 32'(enb), 32'd0);
    avail = 1'b0;
    reset = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/agm_read_unpacker.md
Name: agm_read_unpacker

Overview:
- Read-side consumer of the asymmetric dual-port buffer: 8-bit write port A with an 11-bit address, 32-bit read port B with a 9-bit address.
- Generates addrb/enb on Readclk and absorbs the BRAM read latency.
- Unpacks each 32-bit word into four bytes on a valid/ready stream.
- Pulses rd_ack once per word fetched, so the upstream occupancy logic can decrement its word count.

Parameters:
- ADDR_W, 9, port-B address width (512 words).
- WORD_W, 32, port-B data width.
- BYTE_W, 8, output lane width; WORD_W/BYTE_W = LANES = 4.
- RD_LAT, 1, BRAM read latency in Readclk cycles (legal values 1 or 2).

Ports:
- Readclk, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; clears all state immediately, release is synchronous to Readclk.
- Enrd, input, 1, read enable; when low, no new word fetch starts.
- avail, input, 1, high when at least one complete unread word is in the buffer.
- doutb, input, WORD_W, BRAM port-B read data.
- addrb, output, ADDR_W, BRAM port-B address.
- enb, output, 1, BRAM port-B enable.
- rd_ack, output, 1, one-cycle pulse per word fetched.
- dout, output, BYTE_W, output byte.
- dout_valid, output, 1, dout holds a valid byte.
- dout_ready, input, 1, downstream accepts the byte.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values: addrb=0, enb=0, rd_ack=0, dout=0, dout_valid=0, busy=0, lane_idx=0, word register=0, state=IDLE.
- FSM states: IDLE, FETCH, WAIT, EMIT.
- IDLE: if Enrd && avail, go to FETCH; otherwise stay.
- FETCH (exactly 1 cycle):
  - enb=1 and rd_ack=1 combinationally for this cycle, with addrb holding the fetched address.
  - At the closing edge, addrb increments modulo 2^ADDR_W (511 -> 0); lat_cnt loads RD_LAT-1.
  - Go to WAIT.
- WAIT:
  - enb=0.
  - If lat_cnt==0: capture doutb into the word register at this edge, set lane_idx=0, go to EMIT.
  - Otherwise decrement lat_cnt.
  - Net: first byte is valid RD_LAT+1 cycles after the FETCH cycle.
- EMIT:
  - dout_valid=1; dout = word[lane_idx*8 +: 8]. Little-endian: lane 0 is bits 7:0 and goes out first.
  - On dout_valid && dout_ready: lane_idx increments.
  - On acceptance of lane 3:
    - If Enrd && avail, go directly to FETCH (back-to-back words, one bubble cycle between words in addition to RD_LAT).
    - Otherwise go to IDLE.
  - dout_valid drops in the cycle after the last lane is accepted.
- Handshake rules:
  - dout and dout_valid are registered.
  - dout is stable while dout_valid && !dout_ready.
  - dout_valid never deasserts without acceptance.
- Enrd low during WAIT or EMIT: the current word completes in full; only the start of the next fetch is gated.
- avail low mid-word: no effect until the next fetch decision.
- The block never issues a fetch when avail=0 (empty guard); overflow and full protection are upstream's responsibility.
- doutb is sampled only on the WAIT capture edge; the value on doutb at any other time is ignored.
- Reset asserted mid-operation: everything returns to reset values at once; a word partially emitted is discarded; addrb returns to 0.
- rd_ack count always equals the number of FETCH cycles. Width of rd_ack is exactly 1 cycle even if the FSM is in back-to-back operation.

Test Plan:
- Reset: hold reset=0 with Enrd=1, avail=1 -> addrb=0, enb=0, rd_ack=0, dout_valid=0; release reset -> FETCH on the next edge, addrb=0 presented with enb=1 and rd_ack=1 for one cycle.
- Single word, RD_LAT=1, doutb=32'hDDCCBBAA, dout_ready=1 -> bytes AA, BB, CC, DD on four consecutive cycles starting 2 cycles after FETCH; addrb=1 afterwards; exactly one rd_ack.
- Backpressure: dout_ready=0 for 3 cycles while lane 1 (BB) is presented -> dout holds BB with dout_valid=1; after release, CC and DD follow; no byte lost or duplicated.
- Back-to-back stream: avail=1 for 8 words, model BRAM returns {addr,addr,addr,addr} bytes -> 32 bytes in order, 8 rd_ack pulses, addrb=8 at the end.
- Wrap and empty:
  - Preset by streaming 511 words; words 511 and 0 are read back correctly and addrb wraps 511 -> 0.
  - With avail=0, the FSM stays in IDLE, enb=0, busy=0.
- Mid-operation control:
  - Enrd dropped during lane 1 -> all 4 lanes still emitted, then IDLE.
  - reset pulsed low during lane 2 -> dout_valid=0 and addrb=0 immediately (asynchronously).
